traffic_intersection: RTL and testbench

Parametrised multi-approach intersection controller and successor to the single-signal traffic_light. It serves NUM_DIR approaches round-robin, each through red+yellow, green, yellow and all-red clearance. It adds per-approach pedestrian requests with a walk indication, and a maintenance flashing-yellow mode that is entered only at a safe point. It sits at the top of the traffic demo, driven by a free-running clock and buttons/switches that are already synchronised.

---
 rtl/traffic_intersection_pkg.sv | 17 +
 rtl/traffic_intersection_phase_timer.sv | 38 +++
 rtl/traffic_intersection.sv | 175 +++++++++++++++++
 tb/tb_traffic_intersection.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_intersection_pkg.sv
// Shared phase encodings and sizing helper for the intersection controller.
package traffic_intersection_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_ALLRED = 3'd0;
  localparam phase_t PH_REDYLW = 3'd1;
  localparam phase_t PH_GREEN  = 3'd2;
  localparam phase_t PH_YELLOW = 3'd3;
  localparam phase_t PH_FLASH  = 3'd4;

  // Width of a direction index; never narrower than one bit.
  function automatic int unsigned dir_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_intersection_phase_timer.sv
// Loadable down-counter; holds at zero and flags the terminal count.
module traffic_intersection_phase_timer #(
  parameter int unsigned     CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_intersection.sv
// Round-robin multi-approach intersection controller with pedestrian walk and
// maintenance flashing-yellow mode.
module traffic_intersection
  import traffic_intersection_pkg::*;
#(
  parameter int unsigned NUM_DIR  = 2,
  parameter int unsigned REDYLW_T = 2,
  parameter int unsigned GREEN_T  = 6,
  parameter int unsigned YELLOW_T = 2,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned PED_T    = 4,
  parameter int unsigned FLASH_T  = 1,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned DIR_W   = dir_w(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DIR-1:0] ped_req_i,
  input  logic               maint_i,
  output logic [NUM_DIR-1:0] red_o,
  output logic [NUM_DIR-1:0] yellow_o,
  output logic [NUM_DIR-1:0] green_o,
  output logic [NUM_DIR-1:0] walk_o,
  output logic [DIR_W-1:0]   active_dir_o,
  output logic               in_flash_o
);

  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] REDYLW_LD = CNT_W'(REDYLW_T - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
  localparam logic [CNT_W-1:0] PED_LIM   = CNT_W'(PED_T);
  localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIR - 1);

  phase_t             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d, dir_nxt;
  logic [NUM_DIR-1:0] pend_q, pend_d;
  logic               grant_q, grant_d;
  logic               flash_on_q, flash_on_d;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_load_val;
  logic [CNT_W-1:0]   tmr_cnt;
  logic               tmr_done;
  logic [CNT_W-1:0]   green_elapsed;

  traffic_intersection_phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(ALLRED_LD)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .cnt_o     (tmr_cnt),
    .done_o    (tmr_done)
  );

  assign dir_nxt       = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
  assign green_elapsed = GREEN_LD - tmr_cnt;

  // Phase sequencing, direction advance, pedestrian bookkeeping and flash toggle.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    pend_d       = pend_q | ped_req_i;
    grant_d      = grant_q;
    flash_on_d   = flash_on_q;
    tmr_load     = 1'b0;
    tmr_load_val = ALLRED_LD;
    case (state_q)
      PH_ALLRED: begin
        // Only safe point to enter maintenance mode.
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (maint_i) begin
            state_d      = PH_FLASH;
            tmr_load_val = FLASH_LD;
            flash_on_d   = 1'b1;
          end else begin
            state_d      = PH_REDYLW;
            dir_d        = dir_nxt;
            tmr_load_val = REDYLW_LD;
          end
        end
      end
      PH_REDYLW: begin
        if (tmr_done) begin
          state_d      = PH_GREEN;
          tmr_load     = 1'b1;
          tmr_load_val = GREEN_LD;
          // A request arriving on this very edge is served now.
          grant_d       = pend_q[dir_q] | ped_req_i[dir_q];
          pend_d[dir_q] = 1'b0;
        end
      end
      PH_GREEN: begin
        if (tmr_done) begin
          state_d      = PH_YELLOW;
          tmr_load     = 1'b1;
          tmr_load_val = YELLOW_LD;
        end
      end
      PH_YELLOW: begin
        if (tmr_done) begin
          state_d      = PH_ALLRED;
          tmr_load     = 1'b1;
          tmr_load_val = ALLRED_LD;
        end
      end
      PH_FLASH: begin
        if (!maint_i) begin
          state_d      = PH_ALLRED;
          tmr_load     = 1'b1;
          tmr_load_val = ALLRED_LD;
          flash_on_d   = 1'b0;
        end else if (tmr_done) begin
          flash_on_d   = ~flash_on_q;
          tmr_load     = 1'b1;
          tmr_load_val = FLASH_LD;
        end
      end
      default: begin
        state_d  = PH_ALLRED;
        tmr_load = 1'b1;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PH_ALLRED;
      dir_q      <= LAST_DIR;
      pend_q     <= '0;
      grant_q    <= 1'b0;
      flash_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      grant_q    <= grant_d;
      flash_on_q <= flash_on_d;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    red_o    = '1;
    yellow_o = '0;
    green_o  = '0;
    walk_o   = '0;
    case (state_q)
      PH_REDYLW: yellow_o[dir_q] = 1'b1;
      PH_GREEN: begin
        red_o[dir_q]   = 1'b0;
        green_o[dir_q] = 1'b1;
        walk_o[dir_q]  = grant_q && (green_elapsed < PED_LIM);
      end
      PH_YELLOW: begin
        red_o[dir_q]    = 1'b0;
        yellow_o[dir_q] = 1'b1;
      end
      PH_FLASH: begin
        red_o    = '0;
        yellow_o = {NUM_DIR{flash_on_q}};
      end
      default: ;
    endcase
  end

  assign active_dir_o = dir_q;
  assign in_flash_o   = (state_q == PH_FLASH);

endmodule

// File: tb/tb_traffic_intersection.sv
// Randomised bench: two controller instances (default and 3-approach) compared
// cycle by cycle against a timeline model built from elapsed-time counters.
module tb_traffic_intersection;

  typedef struct {
    int nd, ry, g, y, ar, ped, fl;
  } cfg_t;

  // kind: 0 all-red, 1 red+yellow, 2 green, 3 yellow, 4 flash; e = cycles spent so far.
  typedef struct {
    int       kind;
    int       e;
    int       dir;
    bit [7:0] pend;
    bit       grant;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       maint = 1'b0;
  logic [1:0] req1 = '0;
  logic [2:0] req2 = '0;
  logic [1:0] red1, yel1, grn1, walk1;
  logic [0:0] dir1;
  logic       fl1;
  logic [2:0] red2, yel2, grn2, walk2;
  logic [1:0] dir2;
  logic       fl2;

  int checks = 0;
  int errors = 0;

  cfg_t c[2];
  mdl_t m[2];

  always #5 clk = ~clk;

  traffic_intersection u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .ped_req_i   (req1),
    .maint_i     (maint),
    .red_o       (red1),
    .yellow_o    (yel1),
    .green_o     (grn1),
    .walk_o      (walk1),
    .active_dir_o(dir1),
    .in_flash_o  (fl1)
  );

  traffic_intersection #(
    .NUM_DIR(3),
    .GREEN_T(3),
    .PED_T  (3)
  ) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .ped_req_i   (req2),
    .maint_i     (maint),
    .red_o       (red2),
    .yellow_o    (yel2),
    .green_o     (grn2),
    .walk_o      (walk2),
    .active_dir_o(dir2),
    .in_flash_o  (fl2)
  );

  // At most one approach may show green or yellow outside flash.
  always @(negedge clk) begin
    if (!rst && !fl2) begin
      assert ($onehot0(grn2 | yel2))
      else $error("FAIL invariant dut2 green=%b yellow=%b", grn2, yel2);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int dur(input cfg_t cf, input int kind);
    case (kind)
      0:       return cf.ar;
      1:       return cf.ry;
      2:       return cf.g;
      3:       return cf.y;
      default: return cf.fl;
    endcase
  endfunction

  function automatic mdl_t mdl_reset(input cfg_t cf);
    mdl_t r;
    r.kind  = 0;
    r.e     = 0;
    r.dir   = cf.nd - 1;
    r.pend  = '0;
    r.grant = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input cfg_t cf, input mdl_t s, input bit [7:0] req,
                                    input bit mt);
    mdl_t     n = s;
    bit [7:0] msk = '0;
    for (int i = 0; i < cf.nd; i++) msk[i] = 1'b1;
    n.pend = s.pend | (req & msk);
    if (s.kind == 4) begin
      if (!mt) begin
        n.kind = 0;
        n.e    = 0;
      end else begin
        n.e = s.e + 1;
      end
    end else if (s.e == dur(cf, s.kind) - 1) begin
      n.e = 0;
      case (s.kind)
        0: begin
          if (mt) n.kind = 4;
          else begin
            n.kind = 1;
            n.dir  = (s.dir + 1) % cf.nd;
          end
        end
        1: begin
          n.kind        = 2;
          n.grant       = s.pend[s.dir] | req[s.dir];
          n.pend[s.dir] = 1'b0;
        end
        2: n.kind = 3;
        default: n.kind = 0;
      endcase
    end else begin
      n.e = s.e + 1;
    end
    return n;
  endfunction

  task automatic cmp_unit(input int u, input logic [7:0] r, input logic [7:0] yl,
                          input logic [7:0] g, input logic [7:0] w, input logic [7:0] d,
                          input logic f);
    bit [7:0] er = '0, ey = '0, eg = '0, ew = '0;
    if (m[u].kind == 4) begin
      if ((m[u].e / c[u].fl) % 2 == 0) for (int i = 0; i < c[u].nd; i++) ey[i] = 1'b1;
    end else begin
      for (int i = 0; i < c[u].nd; i++) er[i] = 1'b1;
      case (m[u].kind)
        1: ey[m[u].dir] = 1'b1;
        2: begin
          er[m[u].dir] = 1'b0;
          eg[m[u].dir] = 1'b1;
          ew[m[u].dir] = m[u].grant && (m[u].e < c[u].ped);
        end
        3: begin
          er[m[u].dir] = 1'b0;
          ey[m[u].dir] = 1'b1;
        end
        default: ;
      endcase
    end
    check($sformatf("red%0d", u), 32'(r), 32'(er));
    check($sformatf("yellow%0d", u), 32'(yl), 32'(ey));
    check($sformatf("green%0d", u), 32'(g), 32'(eg));
    check($sformatf("walk%0d", u), 32'(w), 32'(ew));
    check($sformatf("active_dir%0d", u), 32'(d), 32'(m[u].dir));
    check($sformatf("in_flash%0d", u), 32'(f), 32'(m[u].kind == 4));
    if (!f) check($sformatf("one_active%0d", u), 32'($onehot0(g | yl)), 32'd1);
  endtask

  task automatic compare_all();
    cmp_unit(0, 8'(red1), 8'(yel1), 8'(grn1), 8'(walk1), 8'(dir1), fl1);
    cmp_unit(1, 8'(red2), 8'(yel2), 8'(grn2), 8'(walk2), 8'(dir2), fl2);
  endtask

  // Compare current outputs, then drive inputs for the coming edge and advance the model.
  task automatic do_cycle(input bit [7:0] req, input bit mt);
    @(negedge clk);
    compare_all();
    rst   = 1'b0;
    req1  = req[1:0];
    req2  = req[2:0];
    maint = mt;
    m[0]  = mdl_step(c[0], m[0], req, mt);
    m[1]  = mdl_step(c[1], m[1], req, mt);
  endtask

  function automatic bit [7:0] rnd_req(input int unsigned odds);
    bit [7:0] r = '0;
    for (int i = 0; i < 3; i++) r[i] = ($urandom_range(odds) == 0);
    return r;
  endfunction

  initial begin
    bit mt = 1'b0;
    bit found = 1'b0;
    c[0] = '{nd: 2, ry: 2, g: 6, y: 2, ar: 1, ped: 4, fl: 1};
    c[1] = '{nd: 3, ry: 2, g: 3, y: 2, ar: 1, ped: 4 - 1, fl: 1};
    m[0] = mdl_reset(c[0]);
    m[1] = mdl_reset(c[1]);
    #23;
    // Idle rounds: plain sequencing and direction wrap.
    for (int k = 0; k < 50; k++) do_cycle(8'h00, 1'b0);
    // Random pedestrian traffic.
    for (int k = 0; k < 300; k++) do_cycle(rnd_req(5), 1'b0);
    // Random pedestrian traffic with maintenance requests coming and going.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(29) == 0) mt = ~mt;
      do_cycle(rnd_req(5), mt);
    end
    // Run to mid green of approach 1 on the default unit, then reset asynchronously.
    for (int k = 0; k < 200 && !found; k++) begin
      do_cycle(rnd_req(3), 1'b0);
      found = (m[0].kind == 2) && (m[0].dir == 1) && (m[0].e == 2);
    end
    check("reach_dir1_green", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    m[0] = mdl_reset(c[0]);
    m[1] = mdl_reset(c[1]);
    compare_all();
    for (int k = 0; k < 60; k++) do_cycle(8'h00, 1'b0);
    for (int k = 0; k < 200; k++) do_cycle(rnd_req(7), 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
